// File: rtl/core_pkg.sv
// Core-wide shared definitions used by the data-memory path.
//
// XLEN                : machine word width.
// mem_write_control_t : bundle emitted by the data-memory address decode for
//                       non-RAM (MMIO) accesses.
//   addr   - byte address of the access
//   value  - write data (ignored for reads)
//   width  - access width encoding (0 byte, 1 half, 2 word)
//   enable - high for a write, low for a read-only lookup
package core_pkg;

   localparam int XLEN = 32;

   typedef struct packed {
      logic [XLEN-1:0] addr;
      logic [XLEN-1:0] value;
      logic [1:0]      width;
      logic            enable;
   } mem_write_control_t;

endpackage

// File: rtl/mmio_uart_tx_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: register
// offsets within its window, STATUS bit positions, the transmit FSM state
// type and the baud counter reload helper.
package mmio_uart_tx_pkg;

   // Byte offsets of the registers from the block's base address.
   localparam logic [31:0] UART_TXDATA_OFF = 32'd0;
   localparam logic [31:0] UART_STATUS_OFF = 32'd4;
   localparam logic [31:0] UART_BAUD_OFF   = 32'd8;
   localparam logic [31:0] UART_IRQ_EN_OFF = 32'd12;

   // STATUS register bit positions.
   localparam int STATUS_FULL_BIT     = 0;
   localparam int STATUS_EMPTY_BIT    = 1;
   localparam int STATUS_BUSY_BIT     = 2;
   localparam int STATUS_OVERFLOW_BIT = 3;
   localparam int STATUS_COUNT_LSB    = 8;

   typedef enum logic [1:0] {
      UART_IDLE,
      UART_START,
      UART_DATA,
      UART_STOP
   } uart_tx_state_t;

   // A divider of zero is treated as one cycle per bit, so the counter
   // reload never underflows.
   function automatic logic [15:0] baud_reload(input logic [15:0] div);
      return (div == 16'd0) ? 16'd0 : div - 16'd1;
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count, shared by the UART TX path and
// intended for reuse by a later RX block.
//
// Ports:
//   clock, reset - core clock, synchronous active-high reset (empties FIFO)
//   push, din    - enqueue din; ignored while full
//   pop, dout    - dequeue; dout shows the head entry combinationally
//   full, empty  - occupancy flags
//   count        - number of stored entries, 0..depth
//
// depth must be a power of two >= 2 so the pointers wrap naturally.
module sync_fifo #(
   parameter int width = 8,
   parameter int depth = 16
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     push,
   input  logic [width-1:0]         din,
   input  logic                     pop,
   output logic [width-1:0]         dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(depth):0]   count
);

   localparam int addr_w = $clog2(depth);
   localparam logic [addr_w:0]   cnt_one  = (addr_w + 1)'(1);
   localparam logic [addr_w:0]   cnt_full = (addr_w + 1)'(depth);
   localparam logic [addr_w-1:0] ptr_one  = addr_w'(1);

   logic [width-1:0]  mem [depth];
   logic [addr_w-1:0] wr_ptr;
   logic [addr_w-1:0] rd_ptr;
   logic              do_push;
   logic              do_pop;

   assign full    = (count == cnt_full);
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign dout    = mem[rd_ptr];

   // Storage is not reset; only the pointers and count define validity.
   always_ff @(posedge clock) begin
      if (do_push) begin
         mem[wr_ptr] <= din;
      end
   end

   // Pointer and occupancy bookkeeping; a simultaneous push and pop leaves
   // the count unchanged.
   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + ptr_one;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + ptr_one;
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + cnt_one;
            2'b01:   count <= count - cnt_one;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter on the data-memory MMIO path.
// Bytes written to TXDATA are queued in a FIFO and shifted out LSB first.
//
// Register window (byte offsets from base_addr):
//   +0  TXDATA   write enqueues value[7:0], reads 0
//   +4  STATUS   {count[15:8], overflow, busy, empty, full}; any write
//                clears the sticky overflow flag
//   +8  BAUD_DIV clock cycles per bit, bits[15:0]
//   +12 IRQ_EN   only when UART_TX_IRQ_EN is defined:
//                bit0 tx-empty enable, bit1 overflow enable
//
// Ports:
//   clock   - core clock
//   reset   - synchronous active-high reset
//   control - MMIO bundle from the address decode (addr, value, width, enable)
//   r_data  - combinational read data for control.addr
//   tx      - serial output, idle high
//   irq     - registered interrupt (only when UART_TX_IRQ_EN is defined)
//
// Optional feature macro: UART_TX_IRQ_EN.
module mmio_uart_tx
   import core_pkg::*;
   import mmio_uart_tx_pkg::*;
#(
   parameter logic [31:0] base_addr        = 32'h0001_0000,
   parameter int          fifo_depth       = 16,
   parameter int          default_baud_div = 434
) (
   input  logic               clock,
   input  logic               reset,
   input  mem_write_control_t control,
   output logic [XLEN-1:0]    r_data,
   output logic               tx
`ifdef UART_TX_IRQ_EN
   ,
   output logic               irq
`endif
);

   localparam int          cnt_w       = $clog2(fifo_depth) + 1;
   localparam logic [15:0] baud_reset  = 16'(default_baud_div);
   localparam logic [31:0] txdata_addr = base_addr + UART_TXDATA_OFF;
   localparam logic [31:0] status_addr = base_addr + UART_STATUS_OFF;
   localparam logic [31:0] baud_addr   = base_addr + UART_BAUD_OFF;
   localparam logic [31:0] irq_en_addr = base_addr + UART_IRQ_EN_OFF;

   logic             hit_txdata, hit_status, hit_baud, hit_irq_en;
   logic             wr_txdata, wr_status, wr_baud;
   logic [15:0]      baud_div;
   logic             overflow;
   logic             fifo_pop, fifo_full, fifo_empty;
   logic [7:0]       fifo_dout;
   logic [cnt_w-1:0] fifo_count;

   uart_tx_state_t   state, state_next;
   logic [15:0]      baud_cnt;
   logic [15:0]      baud_load;
   logic             baud_zero;
   logic [2:0]       bit_cnt;
   logic [7:0]       shift;
   logic             tx_next;
   logic             busy;
   logic             unused_bits;

   // Word-granular decode: the low two address bits and the access width
   // do not matter, any enabled write to a register hits it.
   assign hit_txdata = (control.addr[31:2] == txdata_addr[31:2]);
   assign hit_status = (control.addr[31:2] == status_addr[31:2]);
   assign hit_baud   = (control.addr[31:2] == baud_addr[31:2]);
   assign hit_irq_en = (control.addr[31:2] == irq_en_addr[31:2]);
   assign wr_txdata  = control.enable && hit_txdata;
   assign wr_status  = control.enable && hit_status;
   assign wr_baud    = control.enable && hit_baud;

   sync_fifo #(
      .width (8),
      .depth (fifo_depth)
   ) u_fifo (
      .clock (clock),
      .reset (reset),
      .push  (wr_txdata),
      .din   (control.value[7:0]),
      .pop   (fifo_pop),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   // Software-visible registers. A write while full is dropped by the FIFO
   // and flagged here, even if the FSM pops on the same edge.
   always_ff @(posedge clock) begin
      if (reset) begin
         baud_div <= baud_reset;
         overflow <= 1'b0;
      end else begin
         if (wr_baud) begin
            baud_div <= control.value[15:0];
         end
         if (wr_status) begin
            overflow <= 1'b0;
         end else if (wr_txdata && fifo_full) begin
            overflow <= 1'b1;
         end
      end
   end

   assign baud_load = baud_reload(baud_div);
   assign baud_zero = (baud_cnt == 16'd0);

   // FSM state register. tx is registered from the decoded bit value, so the
   // line trails the state by one cycle but every bit keeps its full width.
   always_ff @(posedge clock) begin
      if (reset) begin
         state <= UART_IDLE;
         tx    <= 1'b1;
      end else begin
         state <= state_next;
         tx    <= tx_next;
      end
   end

   // FSM next-state logic. STOP chains straight into START when more data is
   // queued so back-to-back frames carry no idle gap.
   always_comb begin
      state_next = state;
      case (state)
         UART_IDLE:  if (!fifo_empty) state_next = UART_START;
         UART_START: if (baud_zero) state_next = UART_DATA;
         UART_DATA:  if (baud_zero && bit_cnt == 3'd7) state_next = UART_STOP;
         UART_STOP:  if (baud_zero) state_next = fifo_empty ? UART_IDLE : UART_START;
         default:    state_next = UART_IDLE;
      endcase
   end

   // FSM outputs: line level, FIFO pop and busy flag.
   always_comb begin
      tx_next  = 1'b1;
      fifo_pop = 1'b0;
      busy     = (state != UART_IDLE);
      case (state)
         UART_IDLE:  fifo_pop = !fifo_empty;
         UART_START: tx_next = 1'b0;
         UART_DATA:  tx_next = shift[0];
         UART_STOP:  fifo_pop = baud_zero && !fifo_empty;
         default:    tx_next = 1'b1;
      endcase
   end

   // Bit timing and shift datapath. The divider is sampled only on reload,
   // so a BAUD_DIV change mid-frame lets the current bit finish unchanged.
   always_ff @(posedge clock) begin
      if (reset) begin
         baud_cnt <= 16'd0;
         bit_cnt  <= 3'd0;
         shift    <= 8'd0;
      end else begin
         if (fifo_pop) begin
            shift    <= fifo_dout;
            bit_cnt  <= 3'd0;
            baud_cnt <= baud_load;
         end else if (state != UART_IDLE) begin
            if (baud_zero) begin
               baud_cnt <= baud_load;
               if (state == UART_DATA) begin
                  shift   <= shift >> 1;
                  bit_cnt <= bit_cnt + 3'd1;
               end
            end else begin
               baud_cnt <= baud_cnt - 16'd1;
            end
         end
      end
   end

`ifdef UART_TX_IRQ_EN
   logic [1:0] irq_en;
   logic       wr_irq_en;

   assign wr_irq_en = control.enable && hit_irq_en;

   // Interrupt enables and the registered interrupt line; software clears the
   // cause through the STATUS and IRQ_EN writes.
   always_ff @(posedge clock) begin
      if (reset) begin
         irq_en <= 2'b00;
         irq    <= 1'b0;
      end else begin
         if (wr_irq_en) begin
            irq_en <= control.value[1:0];
         end
         irq <= (irq_en[0] && fifo_empty && !busy) || (irq_en[1] && overflow);
      end
   end

   assign unused_bits = ^{control.addr[1:0], control.width, control.value[31:16]};
`else
   assign unused_bits = ^{control.addr[1:0], control.width, control.value[31:16], hit_irq_en};
`endif

   // Read mux; unmapped offsets and TXDATA read as zero.
   always_comb begin
      r_data = '0;
      if (hit_status) begin
         r_data[STATUS_FULL_BIT]                  = fifo_full;
         r_data[STATUS_EMPTY_BIT]                 = fifo_empty;
         r_data[STATUS_BUSY_BIT]                  = busy;
         r_data[STATUS_OVERFLOW_BIT]              = overflow;
         r_data[STATUS_COUNT_LSB +: cnt_w]        = fifo_count;
      end else if (hit_baud) begin
         r_data[15:0] = baud_div;
      end
`ifdef UART_TX_IRQ_EN
      else if (hit_irq_en) begin
         r_data[1:0] = irq_en;
      end
`endif
   end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Self-checking bench for mmio_uart_tx. Stimulus pushes every byte the block
// should transmit onto a scoreboard queue; an independent line monitor
// decodes frames from tx and checks them against the queue head, including
// frame spacing for back-to-back traffic. Register reads and cycle-exact
// line checks are compared directly against hand-derived constants.
module tb_mmio_uart_tx;
   import core_pkg::*;

   localparam logic [31:0] BASE   = 32'h0001_0000;
   localparam logic [31:0] STATUS = BASE + 32'd4;
   localparam logic [31:0] BAUD   = BASE + 32'd8;

   typedef struct {
      logic [7:0] data;
      bit         contig;
   } exp_t;

   logic               clock;
   logic               reset;
   mem_write_control_t control;
   logic [XLEN-1:0]    r_data;
   logic               tx;
`ifdef UART_TX_IRQ_EN
   logic               irq;
`endif

   int   total = 0;
   int   bad = 0;
   exp_t sb_q[$];
   int   bit_div = 434;
   bit   mon_active = 1'b0;

   mmio_uart_tx dut (
      .clock   (clock),
      .reset   (reset),
      .control (control),
      .r_data  (r_data),
      .tx      (tx)
`ifdef UART_TX_IRQ_EN
      ,
      .irq     (irq)
`endif
   );

   // Free-running 100 MHz-style clock.
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // Hard stop in case something hangs.
   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: got timeout expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
      end
   endtask

   // One write, registered on the next rising edge; returns 1 time unit
   // after that edge.
   task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] value);
      @(negedge clock);
      control.addr   = addr;
      control.value  = value;
      control.width  = 2'b10;
      control.enable = 1'b1;
      @(posedge clock);
      #1;
      control.enable = 1'b0;
   endtask

   task automatic readReg(input logic [31:0] addr, output logic [31:0] data);
      control.addr   = addr;
      control.enable = 1'b0;
      #1;
      data = r_data;
   endtask

   task automatic setBaud(input int div);
      applyStimulus(BAUD, 32'(div));
      bit_div = (div == 0) ? 1 : div;
   endtask

   task automatic sendByte(input logic [7:0] data, input bit accepted, input bit contig);
      exp_t e;
      applyStimulus(BASE, {24'd0, data});
      if (accepted) begin
         e.data   = data;
         e.contig = contig;
         sb_q.push_back(e);
      end
   endtask

   task automatic resetDut();
      @(negedge clock);
      reset = 1'b1;
      sb_q.delete();
      repeat (2) @(posedge clock);
      #1;
      reset   = 1'b0;
      bit_div = 434;
   endtask

   task automatic waitDrain(input int budget);
      int n = 0;
      while ((sb_q.size() != 0 || mon_active) && n < budget) begin
         @(posedge clock);
         n++;
      end
      checkOutput("drain_in_budget", 32'(n < budget), 32'd1);
   endtask

   // Line monitor: hunts for a falling edge, samples each bit at its centre
   // using the divider in force when the frame started, then scores the
   // byte, the start/stop levels and, for chained frames, the start spacing.
   initial begin
      int         mon_t = 0;
      int         mon_div = 1;
      int         mon_cycle = 0;
      int         mon_start = 0;
      int         last_start = 0;
      int         idx;
      logic       mon_prev = 1'b1;
      logic       start_lvl = 1'b0;
      logic [7:0] mon_byte = 8'd0;
      exp_t       e;
      forever begin
         @(negedge clock);
         mon_cycle++;
         if (reset) begin
            mon_active = 1'b0;
            mon_prev   = 1'b1;
         end else begin
            if (!mon_active) begin
               if (mon_prev && !tx) begin
                  mon_active = 1'b1;
                  mon_t      = 0;
                  mon_div    = bit_div;
                  mon_start  = mon_cycle;
               end
            end else begin
               mon_t++;
            end
            if (mon_active && (mon_t % mon_div) == (mon_div / 2)) begin
               idx = mon_t / mon_div;
               if (idx == 0) begin
                  start_lvl = tx;
               end else if (idx <= 8) begin
                  mon_byte[idx-1] = tx;
               end else begin
                  mon_active = 1'b0;
                  if (sb_q.size() == 0) begin
                     total++;
                     bad++;
                     $display("[TB] FAIL unexpected_frame: got byte 0x%0h expected none", mon_byte);
                  end else begin
                     e = sb_q.pop_front();
                     checkOutput("frame_data", {24'd0, mon_byte}, {24'd0, e.data});
                     checkOutput("frame_start_bit", {31'd0, start_lvl}, 32'd0);
                     checkOutput("frame_stop_bit", {31'd0, tx}, 32'd1);
                     if (e.contig) begin
                        checkOutput("frame_spacing", 32'(mon_start - last_start), 32'(10 * mon_div));
                     end
                  end
                  last_start = mon_start;
               end
            end
            mon_prev = tx;
         end
      end
   end

   // Directed test sequence.
   initial begin
      logic [31:0] d;
      logic [9:0]  frame;

      reset          = 1'b1;
      control        = '0;
      repeat (3) @(posedge clock);
      #1;
      reset = 1'b0;

      // Reset state.
      readReg(STATUS, d);
      checkOutput("reset_status", d, 32'h0000_0002);
      readReg(BAUD, d);
      checkOutput("reset_baud", d, 32'd434);
      checkOutput("reset_tx", {31'd0, tx}, 32'd1);

      // Single 0xA5 frame at 4 cycles per bit, checked cycle by cycle.
      $display("[TB] single frame 0xA5, div 4");
      setBaud(4);
      frame = {1'b1, 8'hA5, 1'b0};
      sendByte(8'hA5, 1'b1, 1'b0);
      checkOutput("latency_edge_n", {31'd0, tx}, 32'd1);
      @(posedge clock);
      #1;
      checkOutput("latency_edge_n1", {31'd0, tx}, 32'd1);
      for (int i = 0; i < 40; i++) begin
         @(posedge clock);
         #1;
         checkOutput("a5_line", {31'd0, tx}, {31'd0, frame[i/4]});
         readReg(STATUS, d);
         checkOutput("a5_busy", {31'd0, d[2]}, 32'(i < 39));
      end
      waitDrain(100);
      repeat (2) @(posedge clock);
      #1;
      readReg(STATUS, d);
      checkOutput("a5_idle_status", d, 32'h0000_0002);

      // 17 back-to-back bytes fit because the first one pops immediately.
      $display("[TB] 17 byte burst, div 2");
      setBaud(2);
      for (int i = 0; i < 17; i++) begin
         sendByte(8'(8'h40 + i), 1'b1, i != 0);
      end
      readReg(STATUS, d);
      checkOutput("burst17_status", d, 32'h0000_1005);
      waitDrain(1500);
      repeat (6) @(posedge clock);

      // 18 back-to-back bytes: the last is dropped and flags overflow.
      $display("[TB] 18 byte burst, div 2");
      for (int i = 0; i < 18; i++) begin
         sendByte(8'(8'h80 + i), i < 17, (i != 0) && (i < 17));
      end
      readReg(STATUS, d);
      checkOutput("burst18_status", d, 32'h0000_100D);
      applyStimulus(STATUS, 32'd0);
      readReg(STATUS, d);
      checkOutput("overflow_cleared", d, 32'h0000_1005);
      waitDrain(1500);
      repeat (6) @(posedge clock);

      // Full FIFO with a write landing on the exact pop edge.
      $display("[TB] write on pop edge while full, div 1000");
      setBaud(1000);
      for (int i = 0; i < 17; i++) begin
         sendByte(8'(8'h10 + i), 1'b1, i != 0);
      end
      repeat (9984) @(posedge clock);
      sendByte(8'hEE, 1'b0, 1'b0);
      readReg(STATUS, d);
      checkOutput("full_pop_status", d, 32'h0000_0F0C);
      resetDut();

      // Divider 0 means one cycle per bit.
      $display("[TB] divider 0 and unmapped addresses");
      setBaud(0);
      sendByte(8'h3C, 1'b1, 1'b0);
      sendByte(8'hC3, 1'b1, 1'b1);
      waitDrain(200);
      readReg(BASE + 32'd16, d);
      checkOutput("unmapped_base16", d, 32'd0);
      readReg(32'h0002_0000, d);
      checkOutput("unmapped_far", d, 32'd0);
      applyStimulus(BASE + 32'd16, 32'hFFFF_FFFF);
      applyStimulus(32'h0002_0000, 32'h0000_00AA);
`ifndef UART_TX_IRQ_EN
      readReg(BASE + 32'd12, d);
      checkOutput("unmapped_base12", d, 32'd0);
      applyStimulus(BASE + 32'd12, 32'hFFFF_FFFF);
      readReg(BASE + 32'd12, d);
      checkOutput("unmapped_base12_after_write", d, 32'd0);
`endif
      repeat (20) @(posedge clock);
      #1;
      readReg(BAUD, d);
      checkOutput("baud_untouched", d, 32'd0);
      readReg(STATUS, d);
      checkOutput("status_untouched", d, 32'h0000_0002);
      checkOutput("tx_untouched", {31'd0, tx}, 32'd1);

      // Reset during data bit 3 of 0x37 (bit 3 is 0).
      $display("[TB] reset mid-frame");
      setBaud(4);
      sendByte(8'h37, 1'b1, 1'b0);
      repeat (18) @(posedge clock);
      #1;
      checkOutput("mid_frame_bit3", {31'd0, tx}, 32'd0);
      @(negedge clock);
      reset = 1'b1;
      sb_q.delete();
      @(posedge clock);
      #1;
      checkOutput("reset_tx_next_cycle", {31'd0, tx}, 32'd1);
      readReg(STATUS, d);
      checkOutput("reset_mid_status", d, 32'h0000_0002);
      @(posedge clock);
      #1;
      reset   = 1'b0;
      bit_div = 434;
      setBaud(3);
      sendByte(8'hE1, 1'b1, 1'b0);
      waitDrain(200);
      repeat (6) @(posedge clock);

`ifdef UART_TX_IRQ_EN
      // Tx-empty interrupt follows the idle-empty condition one edge later.
      $display("[TB] irq");
      #1;
      checkOutput("irq_reset", {31'd0, irq}, 32'd0);
      applyStimulus(BASE + 32'd12, 32'd1);
      @(posedge clock);
      #1;
      checkOutput("irq_idle_empty", {31'd0, irq}, 32'd1);
      readReg(BASE + 32'd12, d);
      checkOutput("irq_en_readback", d, 32'd1);
      setBaud(2);
      sendByte(8'h81, 1'b1, 1'b0);
      @(posedge clock);
      #1;
      checkOutput("irq_queued", {31'd0, irq}, 32'd0);
      repeat (8) @(posedge clock);
      #1;
      checkOutput("irq_sending", {31'd0, irq}, 32'd0);
      waitDrain(200);
      repeat (4) @(posedge clock);
      #1;
      checkOutput("irq_done", {31'd0, irq}, 32'd1);
      applyStimulus(BASE + 32'd12, 32'd0);
      @(posedge clock);
      #1;
      checkOutput("irq_disabled", {31'd0, irq}, 32'd0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
